// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: byte FIFO plus a small sequencer that launches one byte at a
// time into the UART transmitter using its DV / active / done handshake.
module uart_tx_feeder #(
    parameter int UART_DATA_WIDTH = 8,
    parameter int FIFO_DEPTH      = 16,
    parameter int ADDR_WIDTH      = 4
) (
    input  logic                       i_Clock,
    input  logic                       i_Rst_n,
    input  logic                       i_Wr_En,
    input  logic [UART_DATA_WIDTH-1:0] i_Wr_Data,
    input  logic                       i_Flush,
    input  logic                       i_Clr_Ovf,
    output logic                       o_Full,
    output logic                       o_Empty,
    output logic [ADDR_WIDTH:0]        o_Count,
    output logic                       o_Overflow,
    output logic                       o_Busy,
    output logic                       o_Tx_DV,
    output logic [UART_DATA_WIDTH-1:0] o_Tx_Byte,
    input  logic                       i_Tx_Active,
    input  logic                       i_Tx_Done
);

    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_ACT,
        S_WAIT_DONE,
        S_WAIT_CLR
    } state_t;

    state_t state, state_nxt;

    logic [UART_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]      wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]        count_nxt;
    logic                       pop, flush_do, push, ovf_set;

    // A write while full is always dropped, even if a pop frees a slot this cycle.
    assign push    = i_Wr_En && !o_Full && !flush_do;
    assign ovf_set = i_Wr_En && o_Full;
    assign o_Busy  = (state != S_IDLE) || !o_Empty;

    // State register; reset drops any byte in flight and returns to idle.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state and pop/flush decisions; flush only honoured while idle.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        flush_do  = 1'b0;
        case (state)
            S_IDLE: begin
                if (i_Flush) begin
                    flush_do = 1'b1;
                end else if (!o_Empty) begin
                    pop       = 1'b1;
                    state_nxt = S_SEND;
                end
            end
            S_SEND:      state_nxt = S_WAIT_ACT;
            S_WAIT_ACT:  if (i_Tx_Active) state_nxt = S_WAIT_DONE;
            S_WAIT_DONE: if (i_Tx_Done)   state_nxt = S_WAIT_CLR;
            // Wait for done to drop so the transmitter is idle before the next DV.
            S_WAIT_CLR:  if (!i_Tx_Done)  state_nxt = S_IDLE;
            default:     state_nxt = S_IDLE;
        endcase
    end

    // Occupancy after this edge.
    always_comb begin
        count_nxt = o_Count;
        if (flush_do) begin
            count_nxt = '0;
        end else begin
            case ({push, pop})
                2'b10:   count_nxt = o_Count + ONE_C;
                2'b01:   count_nxt = o_Count - ONE_C;
                default: count_nxt = o_Count;
            endcase
        end
    end

    // Storage array; no reset needed, occupancy tracking guards reads.
    always_ff @(posedge i_Clock) begin
        if (push) mem[wr_ptr] <= i_Wr_Data;
    end

    // Pointers wrap naturally at FIFO_DEPTH; count and flags are registered.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            o_Count <= '0;
            o_Full  <= 1'b0;
            o_Empty <= 1'b1;
        end else begin
            if (flush_do) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            o_Count <= count_nxt;
            o_Full  <= (count_nxt == DEPTH_C);
            o_Empty <= (count_nxt == '0);
        end
    end

    // Sticky overflow; a new overflow beats a clear in the same cycle.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n)       o_Overflow <= 1'b0;
        else if (ovf_set)   o_Overflow <= 1'b1;
        else if (i_Clr_Ovf) o_Overflow <= 1'b0;
    end

    // Transmitter interface: DV is a single-cycle pulse, byte held until next pop.
    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            o_Tx_DV   <= 1'b0;
            o_Tx_Byte <= '0;
        end else begin
            o_Tx_DV <= pop;
            if (pop) o_Tx_Byte <= mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed + randomized checks of the feeder against a
// queue-based reference and a behavioural transmitter model.
module tb_uart_tx_feeder;

    localparam int W     = 8;
    localparam int D     = 16;
    localparam int AW    = 4;
    localparam int FRAME = 12;

    logic          i_Clock = 1'b0;
    logic          i_Rst_n = 1'b1;
    logic          i_Wr_En = 1'b0;
    logic [W-1:0]  i_Wr_Data = '0;
    logic          i_Flush = 1'b0;
    logic          i_Clr_Ovf = 1'b0;
    logic          o_Full, o_Empty, o_Overflow, o_Busy, o_Tx_DV;
    logic [AW:0]   o_Count;
    logic [W-1:0]  o_Tx_Byte;
    logic          i_Tx_Active = 1'b0;
    logic          i_Tx_Done = 1'b0;

    int checks = 0;
    int errors = 0;
    int dv_total = 0;
    int done_falls = 0;
    bit tx_stall = 0;
    bit tx_busy = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] rx_q[$];

    uart_tx_feeder #(.UART_DATA_WIDTH(W), .FIFO_DEPTH(D), .ADDR_WIDTH(AW)) dut (
        .i_Clock(i_Clock), .i_Rst_n(i_Rst_n), .i_Wr_En(i_Wr_En), .i_Wr_Data(i_Wr_Data),
        .i_Flush(i_Flush), .i_Clr_Ovf(i_Clr_Ovf), .o_Full(o_Full), .o_Empty(o_Empty),
        .o_Count(o_Count), .o_Overflow(o_Overflow), .o_Busy(o_Busy), .o_Tx_DV(o_Tx_DV),
        .o_Tx_Byte(o_Tx_Byte), .i_Tx_Active(i_Tx_Active), .i_Tx_Done(i_Tx_Done)
    );

    always #5 i_Clock = ~i_Clock;

    // DV pulse monitor.
    initial forever begin
        @(negedge i_Clock);
        if (o_Tx_DV === 1'b1) dv_total++;
    end

    // Transmitter model: on DV, capture byte, active for FRAME cycles, done for 2.
    initial forever begin
        @(negedge i_Clock);
        if (o_Tx_DV === 1'b1 && !tx_stall) begin
            tx_busy = 1;
            rx_q.push_back(o_Tx_Byte);
            @(negedge i_Clock);
            i_Tx_Active = 1'b1;
            repeat (FRAME) @(negedge i_Clock);
            i_Tx_Active = 1'b0;
            i_Tx_Done   = 1'b1;
            repeat (2) @(negedge i_Clock);
            i_Tx_Done = 1'b0;
            done_falls++;
            tx_busy = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Main thread lives 1ns after each falling edge.
    task automatic tick();
        @(negedge i_Clock);
        #1;
    endtask

    task automatic do_reset();
        i_Rst_n = 1'b0;
        tick();
        i_Rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (!(o_Busy === 1'b0 && !tx_busy) && n < 3000) begin
            tick();
            n++;
        end
        chk(tag, (n >= 3000), 0);
    endtask

    task automatic compare_stream(input string tag, input int n);
        chk({tag, "_len"}, rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size() && i < exp_q.size(); i++)
            chk(tag, rx_q[i], exp_q[i]);
    endtask

    // Stream n bytes with random gaps, throttled to keep the FIFO partially full.
    task automatic stream(input int n, input bit rnd_data, output int bad);
        int sent = 0;
        int cyc  = 0;
        bad = 0;
        while (sent < n && cyc < 5000) begin
            if (o_Count < 12 && $urandom_range(0, 3) != 0) begin
                i_Wr_En   = 1'b1;
                i_Wr_Data = rnd_data ? W'($urandom) : W'(sent);
                exp_q.push_back(i_Wr_Data);
                sent++;
            end else begin
                i_Wr_En = 1'b0;
            end
            tick();
            cyc++;
            if (o_Full !== 1'b0 || o_Overflow !== 1'b0) bad++;
        end
        i_Wr_En = 1'b0;
        if (sent < n) bad++;
    endtask

    initial begin
        int dv0, df0, peak, n, bad;

        // Reset state
        #1 i_Rst_n = 1'b0;
        tick();
        chk("rst_empty", o_Empty, 1);
        chk("rst_full", o_Full, 0);
        chk("rst_count", o_Count, 0);
        chk("rst_ovf", o_Overflow, 0);
        chk("rst_dv", o_Tx_DV, 0);
        chk("rst_byte", o_Tx_Byte, 0);
        chk("rst_busy", o_Busy, 0);
        i_Rst_n = 1'b1;
        tick();

        // Single byte: empty drops after the write edge, DV one edge later
        i_Wr_En = 1'b1; i_Wr_Data = 8'h55;
        tick();
        i_Wr_En = 1'b0;
        chk("single_empty", o_Empty, 0);
        chk("single_count", o_Count, 1);
        chk("single_dv_early", o_Tx_DV, 0);
        chk("single_busy", o_Busy, 1);
        tick();
        chk("single_dv", o_Tx_DV, 1);
        chk("single_byte", o_Tx_Byte, 8'h55);
        chk("single_count_pop", o_Count, 0);
        n = 0;
        while (o_Busy !== 1'b0 && n < 200) begin
            tick();
            n++;
        end
        // Busy must fall only after the model's done pulse has ended.
        chk("single_busy_fall", done_falls, 1);
        chk("single_rx_len", rx_q.size(), 1);
        chk("single_rx", rx_q[0], 8'h55);

        // Reset mid-frame
        i_Wr_En = 1'b1; i_Wr_Data = 8'hA5;
        tick();
        i_Wr_Data = 8'h11;
        tick();
        i_Wr_En = 1'b0;
        n = 0;
        while (i_Tx_Active !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("midrst_active_seen", (n >= 50), 0);
        tick(); tick();
        chk("midrst_count_pre", o_Count, 1);
        #2 i_Rst_n = 1'b0;
        #1;
        chk("midrst_count", o_Count, 0);
        chk("midrst_empty", o_Empty, 1);
        chk("midrst_dv", o_Tx_DV, 0);
        chk("midrst_busy", o_Busy, 0);
        chk("midrst_byte", o_Tx_Byte, 0);
        @(negedge i_Clock);
        i_Rst_n = 1'b1;
        dv0 = dv_total;
        repeat (30) tick();
        chk("midrst_no_dv", dv_total - dv0, 0);
        wait_idle("midrst_idle_to");

        // Burst ordering: the first byte pops on the second write edge, so peak is 4
        exp_q.delete(); rx_q.delete();
        dv0 = dv_total; df0 = done_falls; peak = 0;
        for (int i = 1; i <= 5; i++) begin
            i_Wr_En = 1'b1; i_Wr_Data = W'(i);
            exp_q.push_back(W'(i));
            tick();
            if (int'(o_Count) > peak) peak = int'(o_Count);
        end
        i_Wr_En = 1'b0;
        chk("burst_peak", peak, 4);
        wait_idle("burst_idle_to");
        compare_stream("burst", 5);
        chk("burst_dv_cnt", dv_total - dv0, 5);
        chk("burst_done_cnt", done_falls - df0, 5);

        // Full and overflow with a stalled transmitter
        tx_stall = 1;
        for (int i = 0; i < 16; i++) begin
            i_Wr_En = 1'b1; i_Wr_Data = W'(8'h80 + i);
            tick();
        end
        chk("full_count15", o_Count, 15);
        chk("full_not_yet", o_Full, 0);
        tick();
        chk("full_count16", o_Count, 16);
        chk("full_flag", o_Full, 1);
        chk("full_no_ovf", o_Overflow, 0);
        tick();
        i_Wr_En = 1'b0;
        chk("ovf_set", o_Overflow, 1);
        chk("ovf_count", o_Count, 16);
        repeat (3) tick();
        chk("ovf_sticky", o_Overflow, 1);
        i_Wr_En = 1'b1; i_Clr_Ovf = 1'b1;
        tick();
        i_Wr_En = 1'b0;
        chk("ovf_set_wins", o_Overflow, 1);
        tick();
        i_Clr_Ovf = 1'b0;
        chk("ovf_cleared", o_Overflow, 0);
        do_reset();
        tx_stall = 0;
        chk("post_stall_count", o_Count, 0);

        // Flush ignored mid-frame, honoured in idle together with a write
        exp_q.delete(); rx_q.delete();
        df0 = done_falls;
        for (int i = 0; i < 8; i++) begin
            i_Wr_En = 1'b1; i_Wr_Data = W'(8'h60 + i);
            tick();
        end
        i_Wr_En = 1'b0;
        chk("flush_pre_count", o_Count, 7);
        i_Flush = 1'b1;
        tick();
        chk("flush_ignored1", o_Count, 7);
        tick();
        chk("flush_ignored2", o_Count, 7);
        i_Flush = 1'b0;
        n = 0;
        while (done_falls == df0 && n < 200) begin
            tick();
            n++;
        end
        chk("flush_done_to", (n >= 200), 0);
        tick();
        chk("flush_idle_count", o_Count, 7);
        i_Flush = 1'b1; i_Wr_En = 1'b1; i_Wr_Data = 8'hEE;
        tick();
        i_Flush = 1'b0; i_Wr_En = 1'b0;
        chk("flush_count", o_Count, 0);
        chk("flush_empty", o_Empty, 1);
        chk("flush_dv", o_Tx_DV, 0);
        chk("flush_busy", o_Busy, 0);
        dv0 = dv_total;
        repeat (10) tick();
        chk("flush_no_dv", dv_total - dv0, 0);
        chk("flush_rx_len", rx_q.size(), 1);
        chk("flush_rx", rx_q[0], 8'h60);

        // Pointer wrap: 0x00..0x27 streamed through the 16-deep FIFO
        exp_q.delete(); rx_q.delete();
        stream(40, 1'b0, bad);
        chk("wrap_no_full_ovf", bad, 0);
        wait_idle("wrap_idle_to");
        compare_stream("wrap", 40);

        // Random data stream
        exp_q.delete(); rx_q.delete();
        stream(24, 1'b1, bad);
        chk("rand_no_full_ovf", bad, 0);
        wait_idle("rand_idle_to");
        compare_stream("rand", 24);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
